// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    // Default counter/divisor width.
    localparam int CNT_W_DEF   = 26;
    // Default reset divisor: toggle every DEF_DIV+1 cycles.
    localparam int DEF_DIV_DEF = 9;
    // Largest supported channel count.
    localparam int MAX_CH      = 16;

    // Ceiling log2 with a floor of 1, so a single channel still gets a 1-bit select.
    function automatic int clk_div_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisor, toggle and tick.
//
// Write interface: i_wr is a single-cycle strobe with no backpressure; the value on
// i_wr_div is captured on every edge where i_wr is high, and the most recent capture
// is the one that gets applied.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    input  logic             i_en,
    input  logic             i_sync,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic             w_bound;

    // The last cycle of a half period; the only point where a new divisor may take over.
    assign w_bound = (r_cnt == r_act_div);

    // Counter, toggle, tick and divisor hand-over for this channel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_act_div  <= CNT_W'(DEF_DIV);
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            if (i_wr) begin
                r_pend_div <= i_wr_div;
            end
            if (!i_en) begin
                // Parked: output low, and a divisor captured earlier is installed now,
                // so a write made while disabled takes effect on the following edge.
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                if (r_pend) begin
                    r_act_div <= r_pend_div;
                end
                r_pend <= i_wr;
            end else if (i_sync || w_bound) begin
                // Sync restarts the phase low; a boundary toggles. Either way the
                // next half period starts fresh, so the divisor can change safely.
                r_cnt <= '0;
                if (i_sync) begin
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else begin
                    r_clk  <= ~r_clk;
                    r_tick <= ~r_clk;
                end
                if (i_wr) begin
                    r_act_div <= i_wr_div;
                end else if (r_pend) begin
                    r_act_div <= r_pend_div;
                end
                r_pend <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
                if (i_wr) begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers sharing one system clock.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF,
    parameter int CH_W    = clk_div_clog2(NUM_CH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WrEn,
    input  logic [CH_W-1:0]   WrSel,
    input  logic [CNT_W-1:0]  WrDiv,
    input  logic [NUM_CH-1:0] ChEn,
    input  logic              Sync,
    output logic [NUM_CH-1:0] ClkOut,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Pending
);

    logic [NUM_CH-1:0] w_wr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Select values at or above NUM_CH match no channel, so such writes are dropped.
            assign w_wr[gi] = WrEn && (WrSel == CH_W'(gi));

            clk_div_chan #(
                .CNT_W   (CNT_W),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .i_clk    (Clk),
                .i_rst    (Rst),
                .i_wr     (w_wr[gi]),
                .i_wr_div (WrDiv),
                .i_en     (ChEn[gi]),
                .i_sync   (Sync),
                .o_clk    (ClkOut[gi]),
                .o_tick   (Tick[gi]),
                .o_pend   (Pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: per-segment expected waveforms are queued up front
// and popped one entry per clock edge.
module tb_clk_div_multi;

    logic        Clk;
    logic        Rst;
    logic        WrEn;
    logic [1:0]  WrSel;
    logic [25:0] WrDiv;
    logic [3:0]  ChEn;
    logic        Sync;
    logic [3:0]  ClkOut;
    logic [3:0]  Tick;
    logic [3:0]  Pending;

    // Three-channel instance for the out-of-range select case.
    logic        WrEn3;
    logic [1:0]  WrSel3;
    logic [25:0] WrDiv3;
    logic [2:0]  ChEn3;
    logic        Sync3;
    logic [2:0]  ClkOut3;
    logic [2:0]  Tick3;
    logic [2:0]  Pending3;

    clk_div_multi #(.NUM_CH(4)) u_dut (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrSel(WrSel), .WrDiv(WrDiv),
        .ChEn(ChEn), .Sync(Sync), .ClkOut(ClkOut), .Tick(Tick), .Pending(Pending)
    );

    clk_div_multi #(.NUM_CH(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn3), .WrSel(WrSel3), .WrDiv(WrDiv3),
        .ChEn(ChEn3), .Sync(Sync3), .ClkOut(ClkOut3), .Tick(Tick3), .Pending(Pending3)
    );

    // Clock and watchdog.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish by 200000");
        $fatal(1);
    end

    // Scoreboard: word = {Pending[3:0], Tick[3:0], ClkOut[3:0]} after edge k.
    logic [11:0] exp_q[$];
    logic [11:0] e_w[0:63];
    int          n_cmp;
    int          n_bad;
    int          k;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic seg_clear();
        k = 0;
        for (int j = 0; j < 64; j++) e_w[j] = '0;
    endtask

    // Expected divided clock for channel ch over edges k0..k1: the channel sat at
    // cnt=0, ClkOut=0 right after edge 'origin' and runs with the given half period.
    task automatic wave(input int ch, input int k0, input int k1, input int origin, input int half);
        int t;
        for (int j = k0; j <= k1; j++) begin
            t = j - origin;
            e_w[j][ch]     = ((t / half) % 2) == 1;
            e_w[j][4 + ch] = (t > 0) && ((t % (2 * half)) == half);
        end
    endtask

    task automatic pend(input int ch, input int k0, input int k1);
        for (int j = k0; j <= k1; j++) e_w[j][8 + ch] = 1'b1;
    endtask

    task automatic seg_push(input int n);
        for (int j = 1; j <= n; j++) exp_q.push_back(e_w[j]);
    endtask

    // Advance n edges, comparing each against the next queued expectation.
    task automatic run(input int n, input string tag);
        logic [11:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            k++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL %s k=%0d: observed=empty queue expected=queued entry", tag, k);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s k=%0d", tag, k), {Pending, Tick, ClkOut}, e);
            end
        end
    endtask

    task automatic idle_inputs();
        WrEn = 0; WrSel = 0; WrDiv = 0; ChEn = 0; Sync = 0;
        WrEn3 = 0; WrSel3 = 0; WrDiv3 = 0; ChEn3 = 0; Sync3 = 0;
    endtask

    // Reset pulse spanning two edges, released between edges.
    task automatic do_reset(input string tag);
        Rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge Clk);
        #1;
        check(tag, {Pending, Tick, ClkOut}, 12'h000);
        Rst = 1'b0;
        seg_clear();
    endtask

    int c;
    int d;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Rst = 1'b1;
        idle_inputs();
        #1;
        check("reset_t0", {Pending, Tick, ClkOut}, 12'h000);
        check("reset_t0_dut3", {3'b000, Pending3, Tick3, ClkOut3}, 12'h000);

        // All four channels at the default divisor: period 20, first rise at edge 10.
        do_reset("rst_a");
        for (int ch = 0; ch < 4; ch++) wave(ch, 1, 40, 0, 10);
        seg_push(40);
        ChEn = 4'hF;
        run(40, "default_div");

        // Mid-half-period write on channel 1: current half completes, then half 3.
        do_reset("rst_b");
        wave(1, 1, 9, 0, 10);
        wave(1, 10, 30, 7, 3);
        pend(1, 5, 9);
        seg_push(30);
        ChEn = 4'b0010;
        run(4, "wr_mid");
        WrEn = 1; WrSel = 2'd1; WrDiv = 26'd2;
        run(1, "wr_mid");
        WrEn = 0;
        run(25, "wr_mid");

        // Write on channel 2 exactly at its boundary: applied at once, no pending.
        do_reset("rst_c");
        wave(2, 1, 9, 0, 10);
        wave(2, 10, 24, 9, 1);
        seg_push(24);
        ChEn = 4'b0100;
        run(9, "wr_bound");
        WrEn = 1; WrSel = 2'd2; WrDiv = 26'd0;
        run(1, "wr_bound");
        WrEn = 0;
        run(14, "wr_bound");

        // Channels 0 and 3 out of phase, then Sync realigns them.
        do_reset("rst_d");
        wave(0, 1, 12, 0, 10);
        wave(3, 6, 12, 5, 10);
        wave(0, 13, 45, 13, 10);
        wave(3, 13, 45, 13, 10);
        seg_push(45);
        ChEn = 4'b0001;
        run(5, "sync");
        ChEn = 4'b1001;
        run(7, "sync");
        Sync = 1;
        run(1, "sync");
        Sync = 0;
        run(32, "sync");

        // Disable mid-high, write while disabled, re-enable with the new divisor.
        do_reset("rst_e");
        wave(0, 1, 14, 0, 10);
        pend(0, 18, 18);
        wave(0, 22, 45, 21, 5);
        seg_push(45);
        ChEn = 4'b0001;
        run(14, "disable");
        ChEn = 4'b0000;
        run(3, "disable");
        WrEn = 1; WrSel = 2'd0; WrDiv = 26'd4;
        run(1, "disable");
        WrEn = 0;
        run(3, "disable");
        ChEn = 4'b0001;
        run(24, "disable");

        // Async reset mid-run; out-of-range select on the three-channel instance.
        do_reset("rst_f");
        wave(0, 1, 14, 0, 10);
        wave(1, 1, 14, 0, 10);
        wave(3, 1, 14, 0, 10);
        wave(2, 1, 9, 0, 10);
        wave(2, 10, 14, 7, 3);
        pend(2, 3, 9);
        pend(1, 12, 14);
        seg_push(14);
        ChEn = 4'hF;
        ChEn3 = 3'b111;
        run(2, "pre_rst");
        WrEn = 1; WrSel = 2'd2; WrDiv = 26'd2;
        run(1, "pre_rst");
        WrEn = 0;
        run(8, "pre_rst");
        WrEn = 1; WrSel = 2'd1; WrDiv = 26'd5;
        WrEn3 = 1; WrSel3 = 2'd3; WrDiv3 = 26'd1;
        run(1, "pre_rst");
        WrEn = 0;
        WrEn3 = 0;
        run(2, "pre_rst");
        check("dut3_oob_pending", {9'b0, Pending3}, 12'h000);
        check("dut3_clkout", {9'b0, ClkOut3}, 12'h007);
        #3;
        Rst = 1'b1;
        idle_inputs();
        #1;
        check("async_rst", {Pending, Tick, ClkOut}, 12'h000);
        check("async_rst_dut3", {3'b000, Pending3, Tick3, ClkOut3}, 12'h000);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        seg_clear();
        for (int ch = 0; ch < 4; ch++) wave(ch, 1, 25, 0, 10);
        seg_push(25);
        ChEn = 4'hF;
        run(25, "post_rst");

        // Random divisor written while disabled, then enabled.
        for (int it = 0; it < 3; it++) begin
            c = $urandom_range(0, 3);
            d = $urandom_range(0, 6);
            do_reset("rst_rand");
            pend(c, 1, 1);
            wave(c, 3, 4 + 4 * (d + 1), 2, d + 1);
            seg_push(4 + 4 * (d + 1));
            WrEn = 1; WrSel = 2'(c); WrDiv = 26'(d);
            run(1, $sformatf("rand ch%0d div%0d", c, d));
            WrEn = 0;
            run(1, $sformatf("rand ch%0d div%0d", c, d));
            ChEn = 4'(1 << c);
            run(2 + 4 * (d + 1), $sformatf("rand ch%0d div%0d", c, d));
        end

        check("queue_drained", 12'(exp_q.size()), 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel successor to the single fixed-ratio clock divider.
- NUM_CH independent divided-clock/tick generators run from one system clock.
- Each channel's divisor is programmable at run time and changes glitch-free at a half-period boundary.
- Provides per-channel enable, a global phase-align strobe, and a one-cycle tick strobe. Feeds slow-domain logic: display scan, LED blink, debounce sampling, core-throttle enables.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 26, width of each counter and divisor.
- DEF_DIV, 9, reset divisor loaded into every channel (toggle every DEF_DIV+1 cycles).
- CH_W, clog2(NUM_CH) min 1, width of the channel-select field (derived).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- WrEn  in  1  divisor write strobe, one cycle.
- WrSel  in  CH_W  target channel of the write.
- WrDiv  in  CNT_W  new divisor value.
- ChEn  in  NUM_CH  per-channel run enable (level).
- Sync  in  1  one-cycle phase-align strobe for all enabled channels.
- ClkOut  out  NUM_CH  registered divided clocks.
- Tick  out  NUM_CH  one-cycle strobe on each ClkOut rising transition.
- Pending  out  NUM_CH  1 = a written divisor is waiting to be applied.

Behaviour:
- Per-channel state: cnt[CNT_W], act_div[CNT_W], pend_div[CNT_W], pend flag, ClkOut, Tick.
- Reset (async, immediate): cnt=0, act_div=DEF_DIV, pend_div=0, pend=0, ClkOut=0, Tick=0 for all channels.
- Running (ChEn=1, no Sync), each edge:
  - cnt==act_div: cnt<=0; ClkOut<=~ClkOut; Tick<=1 only if ClkOut was 0. This is the boundary.
  - Otherwise: cnt<=cnt+1; ClkOut holds; Tick<=0.
- Half period = act_div+1 cycles; full period = 2*(act_div+1). Div=0 gives Clk/2.
- ClkOut is driven directly from the toggle register; no extra delay stage.
- First rising ClkOut comes act_div+1 cycles after enable or Sync.
- Divisor write (WrEn=1, WrSel<NUM_CH): pend_div<=WrDiv; pend<=1.
  - WrSel>=NUM_CH: write ignored.
  - Repeated writes before apply: last write wins.
- Apply: at a boundary with pend=1: act_div<=pend_div; pend<=0. The new value governs the next half period, so no runt pulse.
- Write coinciding with a boundary on the same channel: WrDiv is applied at that boundary directly, and pend ends 0.
- ChEn=0: cnt<=0, ClkOut<=0, Tick<=0.
  - Any pending divisor is applied immediately; pend<=0.
  - Writes while disabled apply on the next edge.
- ChEn 0->1: counting starts from cnt=0, ClkOut=0.
- Sync=1 (priority over the boundary): every enabled channel gets cnt<=0, ClkOut<=0, Tick<=0, and its pending divisor applied. Disabled channels are unaffected.
- Sync and WrEn in the same cycle: the written value is applied immediately to the target channel.
- Counter wrap: cnt never exceeds act_div. A shrinking divisor applies only at a boundary, so cnt==0 and overshoot cannot occur.
- Pending mirrors pend combinationally from its register.

Decomposition:
- Shared package clk_div_pkg holds:
  - CNT_W default;
  - DEF_DIV default;
  - clog2 function for CH_W;
  - MAX_CH constant (16).
- Sub-module clk_div_chan holds one channel: counter, act/pend divisor, toggle and tick logic.
- Its inputs:
  - wr (WrEn & WrSel==i);
  - WrDiv;
  - ChEn[i];
  - Sync.
- Top clk_div_multi decodes WrSel and instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset then ChEn=1111 with DEF_DIV=9 -> every ClkOut has period 20 cycles, 50% duty, first rise at cycle 10 after enable, Tick high exactly once per 20 cycles, aligned with each rise.
- Write WrSel=1, WrDiv=2 mid-half-period -> Pending[1]=1 until the next boundary, then half periods of 3 cycles; the half-period in progress completes at 10 cycles, with no glitch.
- Write WrSel=2, WrDiv=0 on the exact boundary cycle -> Pending[2] never asserts; ClkOut[2] toggles every cycle from then on, and Tick[2] pulses every 2 cycles.
- Channels 0/3 at DEF_DIV run out of phase, then Sync=1 for one cycle -> both ClkOut drop to 0 next edge, rise together 10 cycles later, with identical Tick timing.
- ChEn[0] drops mid-high-phase -> ClkOut[0]=0 the next edge and stays 0. Write WrDiv=4 while disabled -> Pending clears next edge. Re-enable -> first rise after 5 cycles, period 10.
- Assert Rst asynchronously mid-run and WrSel=3 with NUM_CH=3 -> all outputs 0 immediately without a clock edge, act_div returns to 9, and the out-of-range write leaves every Pending bit 0.
